multicycle_controller: RTL

//  Control FSM that sequences a multicycle MIPS datapath sharing one ALU and one unified memory port.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : shared encodings for the multicycle MIPS control FSM
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_OR    = 2'd3
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder : maps the FSM aluop (and funct for R-type) to alucontrol
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALU_ADD: alucontrol = ALUC_ADD;
      ALU_SUB: alucontrol = ALUC_SUB;
      ALU_OR:  alucontrol = ALUC_OR;
      ALU_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : state register, next-state and output decode for a
// multicycle MIPS datapath with a shared ALU and a stalling memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       signOrZero,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state;
  state_t state_next;
  aluop_t aluop;

  logic pcwrite;
  logic branch;
  logic memwrite_raw;
  logic irwrite_raw;
  logic regwrite_raw;
  logic illegal_raw;
  logic done_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    aluop        = ALU_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    done_raw     = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    signOrZero   = 1'b0;

    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          state_next  = DECODE;
        end
      end
      DECODE: begin
        // Branch target precomputed here so BRANCH only needs the compare.
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:       state_next = EXECUTE;
          OP_LW, OP_SW:   state_next = MEMADR;
          OP_BEQ:         state_next = BRANCH;
          OP_ADDI, OP_ORI: state_next = IMMEXEC;
          OP_J:           state_next = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_next   = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) begin
          done_raw   = 1'b1;
          state_next = FETCH;
        end
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_next   = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        done_raw   = 1'b1;
        state_next = FETCH;
      end
      IMMEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        signOrZero = (op == OP_ORI);
        state_next = IMMWB;
      end
      IMMWB: begin
        regwrite_raw = 1'b1;
        signOrZero   = (op == OP_ORI);
        done_raw     = 1'b1;
        state_next   = FETCH;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        done_raw   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset gates every enable combinationally so an in-flight instruction
  // cannot commit a write during the reset cycle.
  assign pcen       = ~reset & (pcwrite | (branch & zero));
  assign irwrite    = ~reset & irwrite_raw;
  assign regwrite   = ~reset & regwrite_raw;
  assign memwrite   = ~reset & memwrite_raw;
  assign instr_done = ~reset & done_raw;
  assign illegal_op = ~reset & illegal_raw;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

`default_nettype wire
